exec_stage_module: RTL and testbench
====================================

# exec_stage_module

Execute stage of the five-stage ARM pipeline, with the EX/MEM pipeline register and the processor status register (NZCV). Consumes the decoded, registered ID/EX bundle. Computes the ALU result and branch target, then returns status flags to decode and the branch redirect and flush to fetch. Hazard stalls happen upstream, so this block never stalls.

## Interface
- `ADDR_W`, default 32: PC and branch-address width.
- `DATA_W`, default 32: register and ALU width.
- `CMD_W`, default 4: exec command width.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in`, `imm_in`  in  1 each: ID/EX control bits.
- `exec_cmd`  in  CMD_W: ALU operation.
- `pc_in`  in  ADDR_W: PC+4 of the instruction.
- `val_r_n`, `val_r_m`  in  DATA_W: register operands from ID/EX.
- `shift_operand`  in  12: operand-2 field.
- `signed_imm_24`  in  24: branch offset.
- `dest_in`  in  4: destination register.
- `fwd_sel_1`, `fwd_sel_2`  in  2: forwarding select for Rn and Rm. 00 selects ID/EX, 01 selects `mem_fwd_val`, 10 selects `wb_fwd_val`, 11 behaves as 00.
- `mem_fwd_val`, `wb_fwd_val`  in  DATA_W: forwarded results.
- `branch_taken`  out  1: equals `b_in`, combinational. IF selects `branch_addr` and flushes IF/ID and ID/EX.
- `branch_addr`  out  ADDR_W: combinational branch target.
- `status_reg_out`  out  4: NZCV register as {N,Z,C,V}, fed to ID.
- `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`  out  1: registered control bits.
- `alu_result`  out  DATA_W: registered result, or memory address for loads and stores.
- `st_val`  out  DATA_W: registered store data.
- `dest_out`  out  4: registered destination register.

## Operation
- **Operand selection:** val1 is forwarded Rn (per `fwd_sel_1`); fm is forwarded Rm (per `fwd_sel_2`). `st_val` captures fm.
- **val2 priority (first match wins):**
  - `mem_r_en_in | mem_w_en_in`: zero-extended `shift_operand[11:0]`.
  - `imm_in`: {24'b0, `shift_operand[7:0]`} rotated right by 2×`shift_operand[11:8]`.
  - otherwise: fm shifted by `shift_operand[11:7]`, type from `shift_operand[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Shift amount 0 means no shift for every type. Bit 4 (register-specified shift) is ignored.
- **ALU (`exec_cmd`):** C_in = status C.
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: val1+val2.
  - 0011 ADC: val1+val2+C_in.
  - 0100 SUB: val1−val2.
  - 0101 SBC: val1−val2−(1−C_in).
  - 0110 AND, 0111 ORR, 1000 EOR: bitwise.
  - Any other code: result 0, flags unchanged.
  - CMP and TST arrive as SUB and AND with `wb_en_in`=0. LDR and STR arrive as ADD.
- **Flags:**
  - Arithmetic is computed as a 33-bit sum. Subtracts are formed as val1 + ~val2 + carry-in, so C=1 means no borrow.
  - ADD/ADC/SUB/SBC set N=result[31], Z=(result==0), C=bit 32, V=signed overflow of the operation as performed.
  - Logical ops and MOV/MVN set N and Z only; C and V keep their prior values.
- **Branch address:** `branch_addr` = `pc_in` + (sign-extended `signed_imm_24` << 2), with ADDR_W wrap-around.

## Timing
- **Reset:** while `rst`=0, asynchronously clear `status_reg_out`, `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `alu_result`, `st_val` and `dest_out` to 0. Reset asserted mid-operation discards the in-flight EX/MEM contents.
- **EX/MEM latency:** one cycle. Inputs present in cycle k appear on the registered outputs after rising edge k+1.
- **Status register:** loads the new flags at the same edge as EX/MEM, only when `s_in`=1 and `b_in`=0. Otherwise it holds.
- **Flag visibility:** the next instruction sees updated flags in ID one cycle after the setting instruction leaves EX.
- **Branch outputs:** `branch_taken` and `branch_addr` are valid in the same cycle as `b_in`, with zero latency.
- **Branch flushing:** a branch in EX does not itself write EX/MEM. The ID/EX bundle already arrives with wb/mem enables 0.
- **No stall input:** a new bundle is accepted every cycle. Flushed bubbles (all enables 0) pass through.
- **Simultaneous updates:** when `s_in` and a register write coincide, both happen at the same edge.

## Test plan
- **Reset:** hold `rst`=0 with random inputs, then release. All outputs stay 0 until the first edge after release; a MOV r1, #5 then gives `alu_result`=5, `dest_out`=1, `wb_en_out`=1.
- **Immediate rotate:** imm=1, `shift_operand`=0x4FF (0xFF ror 8). Required: val2=0xFF000000, MOV result 0xFF000000.
- **Register shifts:** fm=0x80000001, `shift_operand[11:7]`=1.
  - LSL gives 0x00000002.
  - LSR gives 0x40000000.
  - ASR gives 0xC0000000.
  - ROR gives 0xC0000000.
- **Flags:**
  - ADDS 0x7FFFFFFF+1 gives NZCV=1001.
  - SUBS 5−5 gives 0110.
  - ANDS with prior C=1, V=1 keeps C and V at 1.
  - ADD with `s_in`=0 leaves flags unchanged.
- **Forwarding and memory:** `fwd_sel_1`=01 with `mem_fwd_val`=0x100 and a load with offset 0x008 gives `alu_result`=0x108 and `mem_r_en_out`=1. `fwd_sel_2`=10 on a store gives `st_val`=`wb_fwd_val`.
- **Branch:** `pc_in`=0x20 with `signed_imm_24`=0xFFFFFE gives `branch_addr`=0x18 and `branch_taken`=1 in the same cycle, flags held. Offset 0x000001 gives 0x24.

Source files
------------

// File: rtl/exec_stage_module.sv
// ============================================================================
// exec_stage_module : ARM execute stage with EX/MEM register and NZCV flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_stage_module #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic              imm_in,
  input  logic [CMD_W-1:0]  exec_cmd,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_r_n,
  input  logic [DATA_W-1:0] val_r_m,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  input  logic [3:0]        dest_in,
  input  logic [1:0]        fwd_sel_1,
  input  logic [1:0]        fwd_sel_2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_addr,
  output logic [3:0]        status_reg_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [3:0]        dest_out
);

  localparam logic [CMD_W-1:0] CMD_MOV = CMD_W'(4'b0001);
  localparam logic [CMD_W-1:0] CMD_MVN = CMD_W'(4'b1001);
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] CMD_ADC = CMD_W'(4'b0011);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] CMD_SBC = CMD_W'(4'b0101);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(4'b0110);
  localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(4'b0111);
  localparam logic [CMD_W-1:0] CMD_EOR = CMD_W'(4'b1000);
  localparam int               MSB     = DATA_W - 1;

  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] fm;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic              overflow;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        flags_next;
  logic [ADDR_W-1:0] branch_off;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [4:0] n);
    logic [2*DATA_W-1:0] d;
    d = {x, x} >> n;
    return d[DATA_W-1:0];
  endfunction

  always_comb begin
    case (fwd_sel_1)
      2'b01:   val1 = mem_fwd_val;
      2'b10:   val1 = wb_fwd_val;
      default: val1 = val_r_n;
    endcase
    case (fwd_sel_2)
      2'b01:   fm = mem_fwd_val;
      2'b10:   fm = wb_fwd_val;
      default: fm = val_r_m;
    endcase
  end

  // Memory offset beats immediate beats shifted register.
  always_comb begin
    val2 = '0;
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = DATA_W'(shift_operand);
    end else if (imm_in) begin
      val2 = ror(DATA_W'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = fm << shift_operand[11:7];
        2'b01:   val2 = fm >> shift_operand[11:7];
        2'b10:   val2 = DATA_W'($signed(fm) >>> shift_operand[11:7]);
        default: val2 = ror(fm, shift_operand[11:7]);
      endcase
    end
  end

  // Subtracts run through the adder as val1 + ~val2 + cin, so C=1 means no borrow.
  always_comb begin
    add_b    = (exec_cmd == CMD_SUB || exec_cmd == CMD_SBC) ? ~val2 : val2;
    add_cin  = (exec_cmd == CMD_ADC || exec_cmd == CMD_SBC) ? status_reg_out[1]
                                                             : (exec_cmd == CMD_SUB);
    sum      = {1'b0, val1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    overflow = (val1[MSB] == add_b[MSB]) && (sum[MSB] != val1[MSB]);

    alu_res    = '0;
    flags_next = status_reg_out;
    case (exec_cmd)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res    = sum[DATA_W-1:0];
        flags_next = {sum[MSB], (sum[DATA_W-1:0] == '0), sum[DATA_W], overflow};
      end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        case (exec_cmd)
          CMD_MOV: alu_res = val2;
          CMD_MVN: alu_res = ~val2;
          CMD_AND: alu_res = val1 & val2;
          CMD_ORR: alu_res = val1 | val2;
          default: alu_res = val1 ^ val2;
        endcase
        flags_next = {alu_res[MSB], (alu_res == '0), status_reg_out[1:0]};
      end
      default: begin
        alu_res    = '0;
        flags_next = status_reg_out;
      end
    endcase
  end

  assign branch_off   = {{(ADDR_W-24){signed_imm_24[23]}}, signed_imm_24};
  assign branch_addr  = pc_in + (branch_off << 2);
  assign branch_taken = b_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_reg_out <= '0;
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      mem_w_en_out   <= 1'b0;
      alu_result     <= '0;
      st_val         <= '0;
      dest_out       <= '0;
    end else begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      alu_result   <= alu_res;
      st_val       <= fm;
      dest_out     <= dest_in;
      if (s_in && !b_in) begin
        status_reg_out <= flags_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_stage_module.sv
// ============================================================================
// tb_exec_stage_module : directed self-checking bench for exec_stage_module
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exec_cmd;
  logic [31:0] pc_in, val_r_n, val_r_m, mem_fwd_val, wb_fwd_val;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [1:0]  fwd_sel_1, fwd_sel_2;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_reg_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_result, st_val;
  logic [3:0]  dest_out;

  int n_checks = 0;
  int n_fail   = 0;

  exec_stage_module #(.ADDR_W(32), .DATA_W(32), .CMD_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exec_cmd(exec_cmd),
    .pc_in(pc_in), .val_r_n(val_r_n), .val_r_m(val_r_m),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest_in(dest_in),
    .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status_reg_out(status_reg_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_result(alu_result), .st_val(st_val), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0;
    exec_cmd = 4'h0; pc_in = 0; val_r_n = 0; val_r_m = 0; shift_operand = 0;
    signed_imm_24 = 0; dest_in = 0; fwd_sel_1 = 0; fwd_sel_2 = 0;
    mem_fwd_val = 0; wb_fwd_val = 0;
  endtask

  // Present an ALU op with either an immediate or a register operand 2.
  task automatic alu_op(input logic [3:0] cmd, input logic s, input logic imm,
                        input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so);
    idle();
    exec_cmd = cmd; s_in = s; imm_in = imm; val_r_n = rn; val_r_m = rm;
    shift_operand = so; wb_en_in = 1; dest_in = 4'd2;
  endtask

  initial begin
    // Reset held with random inputs
    rst = 0;
    idle();
    wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; s_in = 1;
    exec_cmd = 4'(($urandom));
    val_r_n = $urandom; val_r_m = $urandom; shift_operand = 12'($urandom);
    dest_in = 4'hF;
    repeat (3) tick();
    check("rst_alu",    alu_result, 32'h0);
    check("rst_st",     st_val, 32'h0);
    check("rst_ctrl",   {28'h0, wb_en_out, mem_r_en_out, mem_w_en_out, 1'b0}, 32'h0);
    check("rst_dest",   {28'h0, dest_out}, 32'h0);
    check("rst_status", {28'h0, status_reg_out}, 32'h0);

    // Release; MOV r1, #5 is captured at the first edge afterwards
    rst = 1;
    idle();
    exec_cmd = 4'b0001; imm_in = 1; shift_operand = 12'h005; wb_en_in = 1; dest_in = 4'd1;
    #1;
    check("rel_hold", alu_result, 32'h0);
    tick();
    check("mov5_alu",  alu_result, 32'd5);
    check("mov5_dest", {28'h0, dest_out}, 32'd1);
    check("mov5_wb",   {31'h0, wb_en_out}, 32'd1);

    // Immediate rotate: 0xFF ror 8
    alu_op(4'b0001, 0, 1, 0, 0, 12'h4FF); tick();
    check("imm_rot", alu_result, 32'hFF000000);

    // Register shifts by 1 of 0x80000001
    alu_op(4'b0001, 0, 0, 0, 32'h80000001, 12'h080); tick();
    check("lsl", alu_result, 32'h00000002);
    alu_op(4'b0001, 0, 0, 0, 32'h80000001, 12'h0A0); tick();
    check("lsr", alu_result, 32'h40000000);
    alu_op(4'b0001, 0, 0, 0, 32'h80000001, 12'h0C0); tick();
    check("asr", alu_result, 32'hC0000000);
    alu_op(4'b0001, 0, 0, 0, 32'h80000001, 12'h0E0); tick();
    check("ror", alu_result, 32'hC0000000);
    alu_op(4'b0001, 0, 0, 0, 32'h80000001, 12'h040); tick();
    check("asr0", alu_result, 32'h80000001);

    // Flags
    alu_op(4'b0010, 1, 1, 32'h7FFFFFFF, 0, 12'h001); tick();
    check("adds_res",  alu_result, 32'h80000000);
    check("adds_nzcv", {28'h0, status_reg_out}, 32'b1001);
    alu_op(4'b0100, 1, 1, 32'd5, 0, 12'h005); tick();
    check("subs_nzcv", {28'h0, status_reg_out}, 32'b0110);
    alu_op(4'b0100, 1, 1, 32'h80000000, 0, 12'h001); tick();
    check("subs_ov_res",  alu_result, 32'h7FFFFFFF);
    check("subs_ov_nzcv", {28'h0, status_reg_out}, 32'b0011);
    alu_op(4'b0110, 1, 1, 32'hF0, 0, 12'h00F); tick();
    check("ands_nzcv", {28'h0, status_reg_out}, 32'b0111);
    alu_op(4'b0010, 0, 1, 32'h7FFFFFFF, 0, 12'h001); tick();
    check("add_nos_res",  alu_result, 32'h80000000);
    check("add_nos_nzcv", {28'h0, status_reg_out}, 32'b0111);
    alu_op(4'b0011, 1, 1, 32'd1, 0, 12'h001); tick();
    check("adcs_res",  alu_result, 32'd3);
    check("adcs_nzcv", {28'h0, status_reg_out}, 32'b0000);
    alu_op(4'b0101, 1, 1, 32'd5, 0, 12'h003); tick();
    check("sbcs_res",  alu_result, 32'd1);
    check("sbcs_nzcv", {28'h0, status_reg_out}, 32'b0010);
    alu_op(4'b0000, 1, 1, 32'd9, 0, 12'h009); tick();
    check("undef_res",  alu_result, 32'h0);
    check("undef_nzcv", {28'h0, status_reg_out}, 32'b0010);
    alu_op(4'b1001, 0, 1, 0, 0, 12'h000); tick();
    check("mvn", alu_result, 32'hFFFFFFFF);
    alu_op(4'b1000, 0, 1, 32'h0F, 0, 12'h0FF); tick();
    check("eor", alu_result, 32'hF0);

    // Forwarded load address
    alu_op(4'b0010, 0, 0, 32'hDEAD, 0, 12'h008);
    fwd_sel_1 = 2'b01; mem_fwd_val = 32'h100; mem_r_en_in = 1; tick();
    check("ldr_addr", alu_result, 32'h108);
    check("ldr_ren",  {31'h0, mem_r_en_out}, 32'd1);

    // Store with WB-forwarded data; sel 11 on Rn behaves as ID/EX
    alu_op(4'b0010, 0, 0, 32'h200, 32'h1234, 12'h004);
    wb_en_in = 0; mem_w_en_in = 1; fwd_sel_1 = 2'b11; fwd_sel_2 = 2'b10;
    mem_fwd_val = 32'h100; wb_fwd_val = 32'hCAFEBABE; tick();
    check("str_addr", alu_result, 32'h204);
    check("str_val",  st_val, 32'hCAFEBABE);
    check("str_wen",  {30'h0, wb_en_out, mem_w_en_out}, 32'b01);

    // Branch: zero-latency outputs, flags held despite s_in
    idle();
    b_in = 1; s_in = 1; imm_in = 1; exec_cmd = 4'b0010; pc_in = 32'h20;
    signed_imm_24 = 24'hFFFFFE;
    #1;
    check("br_taken", {31'h0, branch_taken}, 32'd1);
    check("br_back",  branch_addr, 32'h18);
    signed_imm_24 = 24'h000001;
    #1;
    check("br_fwd", branch_addr, 32'h24);
    tick();
    check("br_nzcv", {28'h0, status_reg_out}, 32'b0010);
    check("br_wb",   {31'h0, wb_en_out}, 32'd0);
    idle();
    #1;
    check("br_off", {31'h0, branch_taken}, 32'd0);

    // Asynchronous reset mid-operation
    alu_op(4'b0001, 1, 1, 0, 0, 12'h0AB); tick();
    check("pre_rst", alu_result, 32'hAB);
    #2 rst = 0;
    #1;
    check("async_alu",  alu_result, 32'h0);
    check("async_nzcv", {28'h0, status_reg_out}, 32'h0);
    check("async_wb",   {31'h0, wb_en_out}, 32'd0);
    rst = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
